// File: rtl/cnn_hw_pkg.sv
// Shared CNN datapath definitions: accumulator width, saturation rails,
// accumulator FSM state type and the signed-overflow test.
package cnn_hw_pkg;

    localparam int ACC_W = 16;
    localparam logic [ACC_W-1:0] ACC_MAX = 16'h7FFF;
    localparam logic [ACC_W-1:0] ACC_MIN = 16'h8000;

    typedef enum logic {
        ACC,
        DONE
    } acc_state_t;

    // Two operands of equal sign producing a result of the other sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/csa_16b.sv
// 16-bit carry-select adder: the low byte ripples, and the high byte is
// precomputed for both carry-in values and chosen by the low-byte carry.
module csa_16b (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic [15:0] S,
    output logic        cout
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    assign lo  = {1'b0, A[7:0]} + {1'b0, B[7:0]} + {8'b0, cin};
    assign hi0 = {1'b0, A[15:8]} + {1'b0, B[15:8]};
    assign hi1 = hi0 + 9'd1;

    assign S    = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
    assign cout = lo[8] ? hi1[8] : hi0[8];

endmodule

// File: rtl/conv_acc_16b.sv
// Windowed signed accumulator around csa_16b with a valid/ready result port.
// Define CONV_ACC_SAT_EN to clamp and freeze the sum at a rail on overflow.
module conv_acc_16b
    import cnn_hw_pkg::*;
#(
    parameter int N_TERMS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(N_TERMS + 1);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             cout_unused;
    logic             accept;
    logic             last_term;
    logic             ovf_now;

    csa_16b u_csa (
        .A    (acc),
        .B    (in_data),
        .cin  (1'b0),
        .S    (sum),
        .cout (cout_unused)
    );

    // in_ready depends only on registered state plus the clear/reset gates,
    // so out_ready never reaches it combinationally.
    assign in_ready  = (state == ACC) && !acc_clr && !rst;
    assign accept    = in_valid && in_ready;
    assign last_term = (cnt == CNT_W'(N_TERMS - 1));
    assign ovf_now   = add_ovf(acc[ACC_W-1], in_data[ACC_W-1], sum[ACC_W-1]);

    assign out_valid = (state == DONE);
    assign out_data  = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        ovf <= ovf | ovf_now;
                        cnt <= last_term ? '0 : cnt + CNT_W'(1);
                        if (last_term) begin
                            state <= DONE;
                        end
`ifdef CONV_ACC_SAT_EN
                        // Once railed, the sum stays frozen for the rest of the window.
                        if (!ovf) begin
                            if (ovf_now) begin
                                acc <= acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
                            end else begin
                                acc <= sum;
                            end
                        end
`else
                        acc <= sum;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_acc_16b.sv
// Self-checking bench for conv_acc_16b: scoreboard of expected window sums,
// a vector table of term/gap patterns, and hand-written corner sequences.
module tb_conv_acc_16b;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
    } result_t;

    typedef struct {
        logic [15:0] term;
        int          gap;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] in_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic [15:0] out_data2;
    logic        out_ovf2;

    result_t sb_q[$];
    int      n_vectors = 0;
    int      n_miscompares = 0;

    always #5 clk = ~clk;

    conv_acc_16b #(.N_TERMS(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_clr   (acc_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    conv_acc_16b #(.N_TERMS(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .acc_clr   (1'b0),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_ovf   (out_ovf2)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failNow(input string name);
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    task automatic pushExpected(input logic [15:0] data, input logic ovf);
        result_t r;
        r.data = data;
        r.ovf  = ovf;
        sb_q.push_back(r);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one term and returns just after the edge on which it is accepted.
    task automatic applyStimulus(input logic [15:0] term);
        int waited = 0;
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = term;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                checkOutput("no_early_valid", {15'b0, out_valid}, 16'h0000);
                done = 1'b1;
            end else if (++waited > 50) begin
                failNow("accept_timeout");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (sb_q.size() != 0) begin
            failNow("drain_timeout");
            sb_q.delete();
        end
    endtask

    // Scoreboard: a result is consumed on every cycle the handshake is offered.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                failNow("unexpected_output");
            end else begin
                result_t r;
                r = sb_q.pop_front();
                checkOutput("window_data", out_data, r.data);
                checkOutput("window_ovf", {15'b0, out_ovf}, {15'b0, r.ovf});
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        vec_t vecs[5];

        vecs[0] = '{term: 16'h0003, gap: 2, exp_data: 16'h001B, exp_ovf: 1'b0};
        vecs[1] = '{term: 16'h0100, gap: 0, exp_data: 16'h0900, exp_ovf: 1'b0};
`ifdef CONV_ACC_SAT_EN
        vecs[2] = '{term: 16'h1000, gap: 1, exp_data: 16'h7FFF, exp_ovf: 1'b1};
        vecs[3] = '{term: 16'hF000, gap: 0, exp_data: 16'h8000, exp_ovf: 1'b1};
`else
        vecs[2] = '{term: 16'h1000, gap: 1, exp_data: 16'h9000, exp_ovf: 1'b1};
        vecs[3] = '{term: 16'hF000, gap: 0, exp_data: 16'h7000, exp_ovf: 1'b1};
`endif
        vecs[4] = '{term: 16'hFFFE, gap: 1, exp_data: 16'hFFEE, exp_ovf: 1'b0};

        rst        = 1'b1;
        acc_clr    = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'h0000;
        out_ready  = 1'b1;
        in_valid2  = 1'b0;
        in_data2   = 16'h0000;
        out_ready2 = 1'b0;

        // Reset held for three cycles with input offered.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {15'b0, in_ready}, 16'h0000);
        checkOutput("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("rst_out_data", out_data, 16'h0000);
        checkOutput("rst_out_ovf", {15'b0, out_ovf}, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", {15'b0, in_ready}, 16'h0001);
        checkOutput("post_rst_in_ready2", {15'b0, in_ready2}, 16'h0001);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Basic back-to-back window with a one-cycle result pulse.
        pushExpected(16'h0009, 1'b0);
        for (int j = 0; j < 9; j++) applyStimulus(16'h0001);
        @(negedge clk);
        checkOutput("valid_latency", {15'b0, out_valid}, 16'h0001);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("valid_pulse_end", {15'b0, out_valid}, 16'h0000);
        checkOutput("ready_after_hs", {15'b0, in_ready}, 16'h0001);
        @(posedge clk);
        #1;

        // Negative terms held under backpressure.
        out_ready = 1'b0;
        pushExpected(16'hFFF7, 1'b0);
        for (int j = 0; j < 9; j++) applyStimulus(16'hFFFF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {15'b0, out_valid}, 16'h0001);
            checkOutput("bp_in_ready", {15'b0, in_ready}, 16'h0000);
            checkOutput("bp_out_data", out_data, 16'hFFF7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", {15'b0, in_ready}, 16'h0001);
        checkOutput("bp_release_acc", out_data, 16'h0000);
        checkOutput("bp_release_ovf", {15'b0, out_ovf}, 16'h0000);
        @(posedge clk);
        #1;

        // Abort mid-window; the term offered alongside the clear is dropped.
        for (int j = 0; j < 4; j++) applyStimulus(16'h0005);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        acc_clr  = 1'b1;
        @(negedge clk);
        checkOutput("clr_in_ready", {15'b0, in_ready}, 16'h0000);
        @(posedge clk);
        #1;
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("clr_acc", out_data, 16'h0000);
        @(posedge clk);
        #1;
        pushExpected(16'h0012, 1'b0);
        for (int j = 0; j < 9; j++) applyStimulus(16'h0002);
        waitDrain();

        // Table of term values and inter-term gaps.
        for (int i = 0; i < 5; i++) begin
            pushExpected(vecs[i].exp_data, vecs[i].exp_ovf);
            for (int j = 0; j < 9; j++) begin
                applyStimulus(vecs[i].term);
                if (j < 8) idleCycles(vecs[i].gap);
            end
            waitDrain();
        end

        // Two-term window overflowing positively.
        in_valid2 = 1'b1;
        in_data2  = 16'h7FFF;
        @(posedge clk);
        #1;
        in_data2 = 16'h0001;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        checkOutput("ovf_out_valid", {15'b0, out_valid2}, 16'h0001);
        checkOutput("ovf_flag", {15'b0, out_ovf2}, 16'h0001);
`ifdef CONV_ACC_SAT_EN
        checkOutput("ovf_data", out_data2, 16'h7FFF);
`else
        checkOutput("ovf_data", out_data2, 16'h8000);
`endif
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ovf_clear_valid", {15'b0, out_valid2}, 16'h0000);
        checkOutput("ovf_clear_flag", {15'b0, out_ovf2}, 16'h0000);
        checkOutput("ovf_clear_data", out_data2, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/conv_acc_16b.md
# conv_acc_16b

Sequential accumulator that consumes a stream of signed 16-bit partial products and sums a fixed number of terms per output. Typical use is a CNN kernel window, e.g. 9 terms for 3x3. The datapath adder is the team's existing `csa_16b` carry-select adder, so this block sits directly downstream of it and wraps it. Completed window sums go to the next layer stage over a valid/ready handshake.

## Interface
Parameters:
- `N_TERMS`, default 9: terms summed per output window; legal range 1..256.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `acc_clr`  in  1  abort the current window; clear accumulator and term count.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_data`  in  16  signed two's-complement partial product.
- `out_valid`  out  1  `out_data` holds a completed window sum.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  16  signed window sum.
- `out_ovf`  out  1  signed overflow occurred at some point in this window.

## Operation
- FSM has two states:
  - ACC: collecting terms.
  - DONE: holding the result.
- Reset drives state=ACC, acc=0x0000, cnt=0, ovf=0. Reset values of outputs: `in_ready`=0 while `rst`=1; `out_valid`=0; `out_data`=0x0000; `out_ovf`=0.
- ACC state:
  - `in_ready`=1 unless `acc_clr`=1.
  - Accept occurs when `in_valid` && `in_ready`. On accept: acc <= S from `csa_16b(A=acc, B=in_data, cin=0)`, and cnt <= cnt+1.
- Overflow detection: signed overflow when acc[15]==in_data[15] and S[15]!=acc[15]. This sets sticky ovf for the window. `cout` is ignored.
- When the accept makes cnt reach `N_TERMS`: state <= DONE, and cnt <= 0.
- DONE state:
  - `in_ready`=0, `out_valid`=1.
  - `out_data`=acc and `out_ovf`=ovf, both held stable until the handshake.
  - On `out_valid` && `out_ready`: acc <= 0, ovf <= 0, state <= ACC.
- `acc_clr`=1, in either state: acc <= 0, cnt <= 0, ovf <= 0, state <= ACC. Any result held in DONE is discarded. `acc_clr` beats a simultaneous input or output handshake.
- `rst` beats everything. Reset in mid-window drops the partial sum with no output.
- `in_valid` low in ACC: no state change. Gaps between terms are allowed.

## Timing
- `out_valid` rises 1 cycle after the accept of the `N_TERMS`-th term.
- Minimum window period is `N_TERMS`+1 cycles: `N_TERMS` accepts plus one DONE cycle with `out_ready`=1.
- `in_ready` is a registered-state decode plus `acc_clr` gating. There is no combinational path from `out_ready` to `in_ready` within a cycle; `in_ready` returns to 1 on the cycle after the output handshake.
- The adder is combinational, so each accumulate completes in a single cycle (one `csa_16b` delay in the acc feedback path).
- `out_data` and `out_ovf` are driven straight from registers.

## Configuration
- `CONV_ACC_SAT_EN` defined:
  - On overflow, acc is clamped to 0x7FFF (positive overflow) or 0x8000 (negative overflow).
  - acc stays frozen at that rail for the rest of the window; later terms still count toward cnt.
  - `out_ovf`=1.
- `CONV_ACC_SAT_EN` undefined:
  - acc takes the wrapped 16-bit sum S.
  - `out_ovf` still reports sticky overflow.

## Structure
- Shared package `cnn_hw_pkg`:
  - `ACC_W`=16.
  - `ACC_MAX`=16'h7FFF and `ACC_MIN`=16'h8000.
  - FSM state typedef `acc_state_t` {ACC, DONE}.
- Sub-module: one instance of the existing `csa_16b` (ports A, B, cin, S, cout), with cin tied to 0. No other sub-modules.
- Counter width is $clog2(`N_TERMS`+1).

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `out_data`=0x0000, `out_ovf`=0; `in_ready`=1 on the first cycle after release.
- Basic window: `N_TERMS`=9, nine back-to-back 0x0001 with `out_ready`=1 -> `out_valid` pulses 1 cycle after the ninth accept, `out_data`=0x0009, `out_ovf`=0.
- Negative terms and backpressure: nine 0xFFFF terms with `out_ready`=0 for 5 cycles -> `out_data`=0xFFF7 held stable while `in_ready`=0; one cycle after `out_ready`=1, `in_ready`=1 and acc=0.
- Overflow: `N_TERMS`=2, terms 0x7FFF then 0x0001 -> `out_ovf`=1; `out_data`=0x7FFF with `CONV_ACC_SAT_EN` defined, 0x8000 without.
- Abort: four 0x0005 terms, then `acc_clr`=1 in the same cycle as `in_valid`=1 with data 0x1234 (term dropped), then nine 0x0002 terms -> `out_data`=0x0012, `out_ovf`=0.
- Gapped input: nine 0x0003 terms, each separated by 2 idle cycles of `in_valid`=0 -> `out_data`=0x001B; `out_valid` is never asserted before the ninth accept.
